// File: rtl/apb_spi_csr.sv
// APB register block for an SPI master: descriptor TX queue, RX queue,
// outstanding-transfer tracking and a level interrupt.
module apb_spi_csr #(
  parameter int          TXQ_DEPTH  = 4,
  parameter int          RXQ_DEPTH  = 4,
  parameter logic [7:0]  CLKDIV_RST = 8'h04
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic [31:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [31:0] stream_data_o,
  output logic        stream_data_vld_o,
  input  logic        stream_data_rdy_i,
  input  logic [31:0] spi_data_rx_i,
  input  logic        spi_data_rx_vld_i,
  input  logic        eot_i,
  output logic [7:0]  spi_clk_div_o,
  output logic        irq_o
);

  localparam int TAW = $clog2(TXQ_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RXQ_DEPTH);
  localparam int RCW = RAW + 1;

  logic [3:0]  cmd_q, addr_q;
  logic [7:0]  len_q, clkdiv_q;
  logic [15:0] wdata_q;
  logic [2:0]  irq_en_q, irq_stat_q, irq_set, irq_clr;
  logic [3:0]  outst_q;

  logic [31:0]    tx_mem [TXQ_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TCW-1:0] tx_cnt;
  logic [31:0]    rx_mem [RXQ_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RCW-1:0] rx_cnt;

  logic acc, wr, rd;
  logic [3:0] sel;
  logic s_cmd, s_addr, s_len, s_wdata, s_rdata;
  logic s_ctrl, s_stat, s_irqen, s_irqs, mapped;
  logic start_req, tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_ovf;
  logic [31:0] status, rdata;
  logic unused_ok;

  assign pready_o = 1'b1;
  assign acc = psel_i & penable_i & pready_o;
  assign wr  = acc & pwrite_i;
  assign rd  = acc & ~pwrite_i;
  assign sel = paddr_i[5:2];

  assign s_cmd   = (sel == 4'd0);
  assign s_addr  = (sel == 4'd1);
  assign s_len   = (sel == 4'd2);
  assign s_wdata = (sel == 4'd3);
  assign s_rdata = (sel == 4'd4);
  assign s_ctrl  = (sel == 4'd5);
  assign s_stat  = (sel == 4'd6);
  assign s_irqen = (sel == 4'd7);
  assign s_irqs  = (sel == 4'd8);
  assign mapped  = |{s_cmd, s_addr, s_len, s_wdata, s_rdata,
                     s_ctrl, s_stat, s_irqen, s_irqs};

  assign start_req = wr & s_ctrl & pwdata_i[0];
  assign tx_full   = (tx_cnt == TCW'(TXQ_DEPTH));
  assign tx_empty  = (tx_cnt == '0);
  assign tx_push   = start_req & ~tx_full;
  assign tx_pop    = ~tx_empty & stream_data_rdy_i;

  // A full RX queue still accepts a word when the head leaves this cycle
  assign rx_full  = (rx_cnt == RCW'(RXQ_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = rd & s_rdata & ~rx_empty;
  assign rx_push  = spi_data_rx_vld_i & (~rx_full | rx_pop);
  assign rx_ovf   = spi_data_rx_vld_i & rx_full & ~rx_pop;

  assign pslverr_o = acc & (~mapped | (start_req & tx_full) |
                            (rd & s_rdata & rx_empty));

  assign stream_data_vld_o = ~tx_empty;
  assign stream_data_o     = tx_mem[tx_rp];
  assign spi_clk_div_o     = clkdiv_q;
  assign irq_o             = |(irq_stat_q & irq_en_q);

  assign irq_set = {tx_pop & ~tx_push & (tx_cnt == TCW'(1)), rx_ovf, eot_i};
  assign irq_clr = (wr & s_irqs) ? pwdata_i[2:0] : 3'b000;

  assign status = {6'b0, rx_empty, tx_full, 8'(rx_cnt), 8'(tx_cnt),
                   outst_q, 3'b0, |outst_q};

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        s_cmd:   rdata = {28'b0, cmd_q};
        s_addr:  rdata = {28'b0, addr_q};
        s_len:   rdata = {24'b0, len_q};
        s_wdata: rdata = {16'b0, wdata_q};
        s_rdata: rdata = rx_empty ? '0 : rx_mem[rx_rp];
        s_ctrl:  rdata = {16'b0, clkdiv_q, 8'b0};
        s_stat:  rdata = status;
        s_irqen: rdata = {29'b0, irq_en_q};
        s_irqs:  rdata = {29'b0, irq_stat_q};
        default: rdata = '0;
      endcase
    end
  end
  assign prdata_o = rdata;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      cmd_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      clkdiv_q   <= CLKDIV_RST;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
    end else begin
      if (wr & s_cmd)   cmd_q    <= pwdata_i[3:0];
      if (wr & s_addr)  addr_q   <= pwdata_i[3:0];
      if (wr & s_len)   len_q    <= pwdata_i[7:0];
      if (wr & s_wdata) wdata_q  <= pwdata_i[15:0];
      if (wr & s_ctrl)  clkdiv_q <= pwdata_i[15:8];
      if (wr & s_irqen) irq_en_q <= pwdata_i[2:0];
      irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      outst_q <= '0;
    end else if (tx_pop & ~eot_i) begin
      if (outst_q != 4'hF) outst_q <= outst_q + 4'd1;
    end else if (eot_i & ~tx_pop) begin
      if (outst_q != 4'h0) outst_q <= outst_q - 4'd1;
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TAW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + RAW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
      rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  always_ff @(posedge pclk_i) begin
    if (tx_push) tx_mem[tx_wp] <= {cmd_q, addr_q, len_q, wdata_q};
    if (rx_push) rx_mem[rx_wp] <= spi_data_rx_i;
  end

  assign unused_ok = ^{paddr_i[31:6], paddr_i[1:0], pwdata_i[31:16]};

endmodule

// File: tb/tb_apb_spi_csr.sv
// Scoreboard bench for apb_spi_csr: descriptor and RX queues are
// modelled with expected-value queues popped as the DUT produces data.
module tb_apb_spi_csr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] sdata;
  logic        svld, srdy;
  logic [31:0] rx_data;
  logic        rx_vld, eot, irq;
  logic [7:0]  div;

  int pass_cnt = 0;
  int total_cnt = 0;
  int hs_cnt = 0;

  logic [31:0] txq [$];
  logic [31:0] rxq [$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  apb_spi_csr dut (
    .pclk_i            (clk),
    .prst_i            (rst),
    .paddr_i           (paddr),
    .psel_i            (psel),
    .penable_i         (penable),
    .pwrite_i          (pwrite),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata),
    .pready_o          (pready),
    .pslverr_o         (pslverr),
    .stream_data_o     (sdata),
    .stream_data_vld_o (svld),
    .stream_data_rdy_i (srdy),
    .spi_data_rx_i     (rx_data),
    .spi_data_rx_vld_i (rx_vld),
    .eot_i             (eot),
    .spi_clk_div_o     (div),
    .irq_o             (irq)
  );

  always @(negedge clk) begin
    if (!rst && svld && srdy) begin
      total_cnt++;
      hs_cnt++;
      if (txq.size() == 0) begin
        $display("FAIL stream_extra got=%h required=none", sdata);
      end else begin
        mon_exp = txq.pop_front();
        if (sdata !== mon_exp)
          $display("FAIL stream_data got=%h required=%h", sdata, mon_exp);
        else
          pass_cnt++;
      end
    end
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                           output logic e);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 e = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d,
                          output logic e);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic eot_pulse();
    @(negedge clk) eot = 1'b1;
    @(negedge clk) eot = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({svld, irq, pslverr} !== 3'b000 || prdata !== 32'h0 || div !== 8'h04)
      $display("FAIL reset_outs got=%b%b%b/%h/%h required=000/0/04",
               svld, irq, pslverr, prdata, div);
    else pass_cnt++;
    rst = 1'b0;
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0200_0000 || e !== 1'b0)
      $display("FAIL reset_status got=%h/%b required=02000000/0", d, e);
    else pass_cnt++;
    apb_read(32'h00, d, e);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL reset_cmd got=%h required=0", d);
    else pass_cnt++;
  endtask

  task automatic test_descriptor();
    logic [31:0] d;
    logic e;
    int h0;
    srdy = 1'b1;
    apb_write(32'h00, 32'h3, e);
    apb_write(32'h04, 32'h5, e);
    apb_write(32'h08, 32'h10, e);
    apb_write(32'h0C, 32'hBEEF, e);
    h0 = hs_cnt;
    txq.push_back(32'h3510_BEEF);
    apb_write(32'h14, 32'h0801, e);
    total_cnt++;
    if (e !== 1'b0 || div !== 8'h08)
      $display("FAIL start_write got=%b/%h required=0/08", e, div);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (hs_cnt - h0 !== 1 || svld !== 1'b0)
      $display("FAIL one_beat got=%0d/%b required=1/0", hs_cnt - h0, svld);
    else pass_cnt++;
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0200_0011)
      $display("FAIL outst_one got=%h required=02000011", d);
    else pass_cnt++;
    apb_read(32'h14, d, e);
    total_cnt++;
    if (d !== 32'h0000_0800)
      $display("FAIL ctrl_read got=%h required=00000800", d);
    else pass_cnt++;
    apb_read(32'h00, d, e);
    total_cnt++;
    if (d !== 32'h3) $display("FAIL cmd_read got=%h required=3", d);
    else pass_cnt++;
    apb_read(32'h24, d, e);
    total_cnt++;
    if (d !== 32'h0 || e !== 1'b1)
      $display("FAIL unmapped_rd got=%h/%b required=0/1", d, e);
    else pass_cnt++;
    apb_write(32'h3C, 32'hFFFF_FFFF, e);
    total_cnt++;
    if (e !== 1'b1) $display("FAIL unmapped_wr got=%b required=1", e);
    else pass_cnt++;
    apb_read(32'h20, d, e);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL tx_empty_irq got=%h required=4", d);
    else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic e;
    apb_write(32'h20, 32'h7, e);
    apb_write(32'h1C, 32'h1, e);
    eot_pulse();
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0200_0000)
      $display("FAIL outst_zero got=%h required=02000000", d);
    else pass_cnt++;
    apb_read(32'h20, d, e);
    total_cnt++;
    if (d !== 32'h1 || irq !== 1'b1)
      $display("FAIL eot_irq got=%h/%b required=1/1", d, irq);
    else pass_cnt++;
    apb_write(32'h20, 32'h1, e);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clear got=%b required=0", irq);
    else pass_cnt++;
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h1;
    penable = 1'b0;
    @(negedge clk);
    penable = 1'b1; eot = 1'b1;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; eot = 1'b0;
    apb_read(32'h20, d, e);
    total_cnt++;
    if (d !== 32'h1 || irq !== 1'b1)
      $display("FAIL set_wins got=%h/%b required=1/1", d, irq);
    else pass_cnt++;
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0200_0000)
      $display("FAIL eot_at_zero got=%h required=02000000", d);
    else pass_cnt++;
    apb_write(32'h20, 32'h7, e);
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    logic e;
    srdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apb_write(32'h0C, 32'hC000 + i, e);
      if (i < 4) txq.push_back(32'h3510_C000 + i);
      apb_write(32'h14, 32'h0801, e);
      total_cnt++;
      if (e !== (i == 4))
        $display("FAIL start_err%0d got=%b required=%b", i, e, i == 4);
      else pass_cnt++;
    end
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0300_0400)
      $display("FAIL tx_full_status got=%h required=03000400", d);
    else pass_cnt++;
    @(negedge clk) srdy = 1'b1;
    for (int i = 0; i < 20 && svld; i++) @(negedge clk);
    total_cnt++;
    if (svld !== 1'b0 || txq.size() != 0)
      $display("FAIL drain got=%b/%0d required=0/0", svld, txq.size());
    else pass_cnt++;
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0200_0041)
      $display("FAIL outst_four got=%h required=02000041", d);
    else pass_cnt++;
    eot_pulse();
    eot_pulse();
  endtask

  task automatic test_rx();
    logic [31:0] d, x;
    logic e;
    apb_write(32'h20, 32'h7, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_data = 32'hA0 + i; rx_vld = 1'b1;
      if (i < 4) rxq.push_back(32'hA0 + i);
    end
    @(negedge clk) rx_vld = 1'b0;
    apb_read(32'h20, d, e);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL rx_ovf got=%h required=2", d);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      apb_read(32'h10, d, e);
      x = rxq.pop_front();
      total_cnt++;
      if (d !== x || e !== 1'b0)
        $display("FAIL rdata%0d got=%h/%b required=%h/0", i, d, e, x);
      else pass_cnt++;
    end
    apb_read(32'h10, d, e);
    total_cnt++;
    if (d !== 32'h0 || e !== 1'b1)
      $display("FAIL rdata_empty got=%h/%b required=0/1", d, e);
    else pass_cnt++;
    apb_write(32'h20, 32'h7, e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data = 32'hB0 + i; rx_vld = 1'b1;
      rxq.push_back(32'hB0 + i);
    end
    @(negedge clk) rx_vld = 1'b0;
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; paddr = 32'h10; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1; rx_vld = 1'b1; rx_data = 32'hB4;
    #1 d = prdata;
    x = rxq.pop_front();
    rxq.push_back(32'hB4);
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; rx_vld = 1'b0;
    total_cnt++;
    if (d !== x) $display("FAIL full_pop got=%h required=%h", d, x);
    else pass_cnt++;
    apb_read(32'h20, d, e);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL no_ovf got=%h required=0", d);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      apb_read(32'h10, d, e);
      x = rxq.pop_front();
      total_cnt++;
      if (d !== x || e !== 1'b0)
        $display("FAIL rdata_b%0d got=%h/%b required=%h/0", i, d, e, x);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic e;
    srdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apb_write(32'h0C, 32'hD000 + i, e);
      txq.push_back(32'h3510_D000 + i);
      apb_write(32'h14, 32'h0801, e);
    end
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0200_0321)
      $display("FAIL pre_reset got=%h required=02000321", d);
    else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    txq.delete();
    #1;
    total_cnt++;
    if (svld !== 1'b0 || div !== 8'h04)
      $display("FAIL mid_reset got=%b/%h required=0/04", svld, div);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0; srdy = 1'b1;
    repeat (3) @(negedge clk);
    apb_read(32'h18, d, e);
    total_cnt++;
    if (d !== 32'h0200_0000 || svld !== 1'b0 || div !== 8'h04)
      $display("FAIL post_reset got=%h/%b/%h required=02000000/0/04",
               d, svld, div);
    else pass_cnt++;
  endtask

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    srdy = 1'b0; rx_data = '0; rx_vld = 1'b0; eot = 1'b0;
    test_reset();
    test_descriptor();
    test_irq();
    test_tx_full();
    test_rx();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/apb_spi_csr.md
APB_SPI_CSR -- requirements
Module: apb_spi_csr

Interface
REQ-001 Parameter TXQ_DEPTH, default 4: descriptor queue depth; power of two, at least 2.
REQ-002 Parameter RXQ_DEPTH, default 4: receive queue depth; power of two, at least 2.
REQ-003 Parameter CLKDIV_RST, default 8'h04: reset value of the clock divider.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 pclk_i  in  1  clock.
REQ-006 prst_i  in  1  asynchronous active-high reset.
REQ-007 paddr_i  in  32  APB byte address; bits [5:2] select the register.
REQ-008 psel_i, penable_i, pwrite_i  in  1 each  APB control.
REQ-009 pwdata_i  in  32  APB write data.
REQ-010 prdata_o  out  32  APB read data.
REQ-011 pready_o  out  1  constant 1 (zero wait states).
REQ-012 pslverr_o  out  1  error response during the access phase.
REQ-013 stream_data_o  out  32  descriptor {CMD[3:0], ADDR[3:0], LEN[7:0], WDATA[15:0]}.
REQ-014 stream_data_vld_o  out  1  / stream_data_rdy_i  in  1  descriptor handshake.
REQ-015 spi_data_rx_i  in  32  / spi_data_rx_vld_i  in  1  receive word, single-cycle valid.
REQ-016 eot_i  in  1  single-cycle end-of-transfer pulse.
REQ-017 spi_clk_div_o  out  8  divider value.
REQ-018 irq_o  out  1  level interrupt.

Function
REQ-019 Register map (offset, access):
- 0x00 CMD, RW
- 0x04 ADDR, RW
- 0x08 LEN, RW
- 0x0C WDATA, RW
- 0x10 RDATA, RO with pop
- 0x14 CTRL, RW: bit0 START (write-only, reads 0), [15:8] CLKDIV
- 0x18 STATUS, RO
- 0x1C IRQ_EN, RW [2:0]
- 0x20 IRQ_STAT, W1C [2:0]
REQ-020 An access completes in the cycle where psel_i, penable_i and pready_o are all 1; writes take effect on that clock edge.
REQ-021 prdata_o is combinational during a read access phase and is 0 otherwise.
REQ-022 Unmapped offsets: reads return 0, writes are ignored, and pslverr_o is 1.
REQ-023 Writing CTRL with bit0=1 pushes the current {CMD, ADDR, LEN, WDATA} into the TX queue. If the same write also changes CLKDIV, CLKDIV updates in the same cycle.
REQ-024 START with the TX queue full (judged before any same-cycle pop): no push, pslverr_o=1, CLKDIV still updates.
REQ-025 TX queue is a FIFO; stream_data_vld_o = not empty; stream_data_o = head entry; the head pops on stream_data_vld_o && stream_data_rdy_i.
REQ-026 spi_data_rx_vld_i pushes spi_data_rx_i into the RX queue.
- If the queue is full with no same-cycle pop: word dropped, IRQ_STAT[1] (RXOVF) set.
- If the queue is full and popped in the same cycle: push accepted.
REQ-027 A read of RDATA returns the RX head and pops it. With the RX queue empty it returns 0, pslverr_o=1, and does not pop.
REQ-028 OUTST counter (4 bits, saturating at 15): +1 per descriptor handshake, -1 per eot_i; same-cycle handshake and eot_i leave it unchanged; eot_i at 0 is ignored.
REQ-029 STATUS fields:
- [0] BUSY = (OUTST != 0)
- [7:4] OUTST
- [15:8] TX count
- [23:16] RX count
- [24] TX full
- [25] RX empty
REQ-030 IRQ_STAT set sources:
- [0] on eot_i
- [1] on RX overflow
- [2] when the TX queue goes from non-empty to empty
REQ-031 IRQ_STAT write-1-clears; a set event in the same cycle as a clear wins.
REQ-032 irq_o = |(IRQ_STAT & IRQ_EN), combinational from registers.
REQ-033 spi_clk_div_o = CTRL[15:8].

Reset
REQ-034 While prst_i=1:
- CMD, ADDR, LEN, WDATA, IRQ_EN, IRQ_STAT, OUTST = 0
- CLKDIV = CLKDIV_RST
- both queues empty
- stream_data_vld_o=0, irq_o=0, pslverr_o=0 (prdata_o=0 per REQ-021)
REQ-035 Reset asserted mid-transfer discards queue contents immediately; no descriptor is issued after release until a new START.

Verification
REQ-036 Write CMD=0x3, ADDR=0x5, LEN=0x10, WDATA=0xBEEF, then CTRL=0x0801 with rdy=1 -> stream_data_o=0x3510BEEF valid for one cycle; spi_clk_div_o=0x08.
REQ-037 Hold rdy=0 and issue 5 STARTs with depth 4 -> the first 4 return pslverr_o=0, the 5th returns pslverr_o=1; STATUS[15:8]=4 and [24]=1.
REQ-038 Push 5 RX words 0xA0..0xA4 with depth 4 and no reads -> IRQ_STAT=0x2; RDATA reads return 0xA0..0xA3; the 5th RDATA read returns 0 with pslverr_o=1.
REQ-039 IRQ_EN=0x1, one descriptor handshake, then eot_i -> OUTST 1 then 0, IRQ_STAT[0]=1, irq_o=1; write IRQ_STAT=0x1 -> irq_o=0; clear coincident with eot_i -> bit stays 1.
REQ-040 Assert prst_i with 3 descriptors queued and OUTST=2 -> vld=0, STATUS=0x02000000, spi_clk_div_o=0x04 at once and after release.
